// File: rtl/npc_bpu_gen.sv
// npc_bpu_gen: fetch PC generator with BTB, local-history/PHT direction predictor
// and a circular return-address stack. Emits one 8-byte fetch block per cycle.
// Optional feature macro: BPU_RAS_REPAIR_EN restores the RAS pointer from the value
// echoed back with a mispredicted correction.
module npc_bpu_gen #(
    parameter logic [31:0] RESET_PC   = 32'h1c00_0000,
    parameter int          BTB_DEPTH  = 64,
    parameter int          TAG_WIDTH  = 8,
    parameter int          BHT_DEPTH  = 64,
    parameter int          HIST_WIDTH = 5,
    parameter int          PHT_DEPTH  = 256,
    parameter int          RAS_DEPTH  = 8,
    localparam int         RAS_PW     = $clog2(RAS_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rst_jmp,
    input  logic [31:0]           rst_target,
    input  logic                  ready_i,
    output logic [63:0]           pc_o,
    output logic [1:0]            valid_o,
    output logic                  pred_taken_o,
    output logic                  pred_lane_o,
    output logic [31:0]           pred_target_o,
    output logic [HIST_WIDTH-1:0] pred_hist_o,
    output logic [RAS_PW-1:0]     pred_ras_ptr_o,
    input  logic                  cor_valid_i,
    input  logic [31:0]           cor_pc_i,
    input  logic [31:0]           cor_target_i,
    input  logic                  cor_taken_i,
    input  logic [1:0]            cor_type_i,
    input  logic [HIST_WIDTH-1:0] cor_hist_i,
    input  logic                  cor_miss_i,
    input  logic [RAS_PW-1:0]     cor_ras_ptr_i
);
    localparam int BTB_IW = $clog2(BTB_DEPTH);
    localparam int BHT_IW = $clog2(BHT_DEPTH);
    localparam int PHT_IW = $clog2(PHT_DEPTH);
    localparam int PHT_SH = PHT_IW - HIST_WIDTH;

    localparam logic [1:0] BR_COND   = 2'b00;
    localparam logic [1:0] BR_DIRECT = 2'b01;
    localparam logic [1:0] BR_CALL   = 2'b10;
    localparam logic [1:0] BR_RET    = 2'b11;
    localparam logic [RAS_PW-1:0] RAS_ONE = {{(RAS_PW-1){1'b0}}, 1'b1};

    // PHT index: history shifted to the top bits, folded with the branch word address
    function automatic logic [PHT_IW-1:0] pht_idx(input logic [HIST_WIDTH-1:0] h,
                                                   input logic [31:0] a);
        logic [PHT_IW-1:0] hx;
        hx = PHT_IW'(h);
        return (hx << PHT_SH) ^ a[2 +: PHT_IW];
    endfunction

    // 2-bit saturating counter step
    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        logic [1:0] n;
        if (up) begin
            n = (c == 2'b11) ? c : c + 2'b01;
        end else begin
            n = (c == 2'b00) ? c : c - 2'b01;
        end
        return n;
    endfunction

    // state
    logic [31:0]           r_pc;
    logic                  r_btb_vld  [BTB_DEPTH];
    logic [TAG_WIDTH-1:0]  r_btb_tag  [BTB_DEPTH];
    logic                  r_btb_lane [BTB_DEPTH];
    logic [1:0]            r_btb_type [BTB_DEPTH];
    logic [31:0]           r_btb_tgt  [BTB_DEPTH];
    logic [HIST_WIDTH-1:0] r_bht      [BHT_DEPTH];
    logic [1:0]            r_pht      [PHT_DEPTH];
    logic [31:0]           r_ras      [RAS_DEPTH];
    logic [RAS_PW-1:0]     r_ras_ptr;

    // lookup wires
    logic [BTB_IW-1:0]     w_btb_idx;
    logic [TAG_WIDTH-1:0]  w_tag;
    logic                  w_btb_lane;
    logic [1:0]            w_type;
    logic                  w_hit;
    logic [31:0]           w_br_pc;
    logic [HIST_WIDTH-1:0] w_hist;
    logic [1:0]            w_cnt;
    logic                  w_taken;
    logic [31:0]           w_tgt;
    logic                  w_lane_out;
    logic [1:0]            w_valid;
    logic                  w_fire;
    logic                  w_repair;

    // RAS next-state wires
    logic [RAS_PW-1:0]     w_ras_ptr_nxt;
    logic                  w_ras_we;
    logic [RAS_PW-1:0]     w_ras_waddr;
    logic [31:0]           w_ras_wdata;

    assign w_btb_idx  = r_pc[3 +: BTB_IW];
    assign w_tag      = r_pc[3 + BTB_IW +: TAG_WIDTH];
    assign w_btb_lane = r_btb_lane[w_btb_idx];
    assign w_type     = r_btb_type[w_btb_idx];
    // an entry for lane 0 is behind the fetch point when the block starts at pc[2]=1
    assign w_hit      = r_btb_vld[w_btb_idx] && (r_btb_tag[w_btb_idx] == w_tag)
                        && (w_btb_lane || !r_pc[2]);
    assign w_br_pc    = w_hit ? {r_pc[31:3], w_btb_lane, 2'b00} : r_pc;
    assign w_hist     = r_bht[w_br_pc[2 +: BHT_IW]];
    assign w_cnt      = r_pht[pht_idx(w_hist, w_br_pc)];
    // output lane numbering starts at pc, so a pc[2]=1 block has the branch in lane 0
    assign w_lane_out = w_btb_lane & ~r_pc[2];
    assign w_fire     = ~rst & ready_i & ~rst_jmp & w_taken;

    // direction and target selection for the current block
    always_comb begin
        w_taken = 1'b0;
        w_tgt   = r_btb_tgt[w_btb_idx];
        if (w_hit) begin
            case (w_type)
                BR_COND:   w_taken = w_cnt[1];
                BR_DIRECT: w_taken = 1'b1;
                BR_CALL:   w_taken = 1'b1;
                BR_RET: begin
                    w_taken = 1'b1;
                    w_tgt   = r_ras[r_ras_ptr];
                end
                default:   w_taken = 1'b0;
            endcase
        end else begin
            w_taken = 1'b0;
        end
    end

    // lane valid mask, truncated after a taken branch in lane 0
    always_comb begin
        w_valid = 2'b11;
        if (rst) begin
            w_valid = 2'b00;
        end else if (w_taken && !w_lane_out) begin
            w_valid = 2'b01;
        end else if (r_pc[2]) begin
            w_valid = 2'b01;
        end else begin
            w_valid = 2'b11;
        end
    end

    assign pc_o           = {r_pc + 32'd4, r_pc};
    assign valid_o        = w_valid;
    assign pred_taken_o   = w_taken & ~rst;
    assign pred_lane_o    = w_lane_out;
    assign pred_target_o  = w_tgt;
    assign pred_hist_o    = w_hist;
    assign pred_ras_ptr_o = r_ras_ptr;

`ifdef BPU_RAS_REPAIR_EN
    assign w_repair = cor_valid_i & cor_miss_i;
`else
    logic w_unused_cor;
    assign w_repair     = 1'b0;
    assign w_unused_cor = ^{cor_miss_i, cor_ras_ptr_i, cor_pc_i};
`endif

    // RAS pointer/entry next state: repair first, then speculative push/pop
    always_comb begin
        w_ras_ptr_nxt = r_ras_ptr;
        w_ras_we      = 1'b0;
        w_ras_waddr   = r_ras_ptr + RAS_ONE;
        w_ras_wdata   = w_br_pc + 32'd4;
        if (w_repair) begin
            case (cor_type_i)
                BR_CALL: begin
                    w_ras_ptr_nxt = cor_ras_ptr_i + RAS_ONE;
                    w_ras_we      = 1'b1;
                    w_ras_waddr   = cor_ras_ptr_i + RAS_ONE;
                    w_ras_wdata   = cor_pc_i + 32'd4;
                end
                BR_RET:  w_ras_ptr_nxt = cor_ras_ptr_i - RAS_ONE;
                default: w_ras_ptr_nxt = cor_ras_ptr_i;
            endcase
        end else if (w_fire && (w_type == BR_CALL)) begin
            w_ras_ptr_nxt = r_ras_ptr + RAS_ONE;
            w_ras_we      = 1'b1;
        end else if (w_fire && (w_type == BR_RET)) begin
            w_ras_ptr_nxt = r_ras_ptr - RAS_ONE;
        end else begin
            w_ras_ptr_nxt = r_ras_ptr;
        end
    end

    // fetch PC register with redirect > stall > predicted > sequential priority
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (rst_jmp) begin
            r_pc <= rst_target;
        end else if (!ready_i) begin
            r_pc <= r_pc;
        end else if (w_taken) begin
            r_pc <= w_tgt;
        end else begin
            r_pc <= {r_pc[31:3] + 29'd1, 3'b000};
        end
    end

    // return stack storage and pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ras_ptr <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= 32'd0;
        end else begin
            r_ras_ptr <= w_ras_ptr_nxt;
            if (w_ras_we) r_ras[w_ras_waddr] <= w_ras_wdata;
        end
    end

    // BTB allocation on taken corrections
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_btb_vld[i]  <= 1'b0;
                r_btb_tag[i]  <= '0;
                r_btb_lane[i] <= 1'b0;
                r_btb_type[i] <= 2'b00;
                r_btb_tgt[i]  <= 32'd0;
            end
        end else if (cor_valid_i && cor_taken_i) begin
            r_btb_vld[cor_pc_i[3 +: BTB_IW]]  <= 1'b1;
            r_btb_tag[cor_pc_i[3 +: BTB_IW]]  <= cor_pc_i[3 + BTB_IW +: TAG_WIDTH];
            r_btb_lane[cor_pc_i[3 +: BTB_IW]] <= cor_pc_i[2];
            r_btb_type[cor_pc_i[3 +: BTB_IW]] <= cor_type_i;
            r_btb_tgt[cor_pc_i[3 +: BTB_IW]]  <= cor_target_i;
        end
    end

    // direction tables train on conditional corrections only
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= '0;
            for (int i = 0; i < PHT_DEPTH; i++) r_pht[i] <= 2'b01;
        end else if (cor_valid_i && (cor_type_i == BR_COND)) begin
            r_pht[pht_idx(cor_hist_i, cor_pc_i)] <=
                sat2(r_pht[pht_idx(cor_hist_i, cor_pc_i)], cor_taken_i);
            r_bht[cor_pc_i[2 +: BHT_IW]] <=
                {r_bht[cor_pc_i[2 +: BHT_IW]][HIST_WIDTH-2:0], cor_taken_i};
        end
    end
endmodule

// File: tb/tb_npc_bpu_gen.sv
// Scoreboard bench for npc_bpu_gen: directed stimulus pushes expected output values
// tagged with the cycle they apply to; a negedge monitor pops and compares them.
module tb_npc_bpu_gen;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int RAS_PW = 3;
    localparam int HW     = 5;

    localparam int S_PC0 = 0, S_PC1 = 1, S_VALID = 2, S_TAKEN = 3,
                   S_LANE = 4, S_TGT = 5, S_RPTR = 6, S_HIST = 7;

    logic              clk = 1'b0;
    logic              rst, rst_jmp, ready_i;
    logic [31:0]       rst_target;
    logic [63:0]       pc_o;
    logic [1:0]        valid_o;
    logic              pred_taken_o, pred_lane_o;
    logic [31:0]       pred_target_o;
    logic [HW-1:0]     pred_hist_o;
    logic [RAS_PW-1:0] pred_ras_ptr_o;
    logic              cor_valid_i, cor_taken_i, cor_miss_i;
    logic [31:0]       cor_pc_i, cor_target_i;
    logic [1:0]        cor_type_i;
    logic [HW-1:0]     cor_hist_i;
    logic [RAS_PW-1:0] cor_ras_ptr_i;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;

    npc_bpu_gen dut (
        .clk(clk), .rst(rst), .rst_jmp(rst_jmp), .rst_target(rst_target),
        .ready_i(ready_i), .pc_o(pc_o), .valid_o(valid_o),
        .pred_taken_o(pred_taken_o), .pred_lane_o(pred_lane_o),
        .pred_target_o(pred_target_o), .pred_hist_o(pred_hist_o),
        .pred_ras_ptr_o(pred_ras_ptr_o), .cor_valid_i(cor_valid_i),
        .cor_pc_i(cor_pc_i), .cor_target_i(cor_target_i), .cor_taken_i(cor_taken_i),
        .cor_type_i(cor_type_i), .cor_hist_i(cor_hist_i), .cor_miss_i(cor_miss_i),
        .cor_ras_ptr_i(cor_ras_ptr_i)
    );

    always #5 clk = ~clk;

    // cycle stamp shared by stimulus and monitor
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_val(input int sel);
        case (sel)
            S_PC0:   return pc_o[31:0];
            S_PC1:   return pc_o[63:32];
            S_VALID: return {30'd0, valid_o};
            S_TAKEN: return {31'd0, pred_taken_o};
            S_LANE:  return {31'd0, pred_lane_o};
            S_TGT:   return pred_target_o;
            S_RPTR:  return {29'd0, pred_ras_ptr_o};
            S_HIST:  return {27'd0, pred_hist_o};
            default: return 32'hdead_beef;
        endcase
    endfunction

    // monitor: compare every expectation stamped for this cycle
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            check_eq(e.tag, dut_val(e.sel), e.val);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sb_push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.val = val; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [31:0] tgt);
        rst_jmp = 1'b1;
        rst_target = tgt;
        step();
        rst_jmp = 1'b0;
    endtask

    task automatic correct(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                           input logic [1:0] ty, input logic [HW-1:0] h);
        cor_valid_i = 1'b1; cor_pc_i = pc; cor_target_i = tgt;
        cor_taken_i = tk; cor_type_i = ty; cor_hist_i = h;
        cor_miss_i = 1'b0; cor_ras_ptr_i = 3'd0;
        step();
        cor_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst_jmp = 1'b0; rst_target = 32'd0; ready_i = 1'b1;
        cor_valid_i = 1'b0; cor_pc_i = 32'd0; cor_target_i = 32'd0; cor_taken_i = 1'b0;
        cor_type_i = 2'b00; cor_hist_i = 5'd0; cor_miss_i = 1'b0; cor_ras_ptr_i = 3'd0;

        // reset
        step();
        sb_push("rst_valid", S_VALID, 32'd0);
        sb_push("rst_taken", S_TAKEN, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb_push("seq_pc", S_PC0, RESET_PC + 32'(8 * i));
            sb_push("seq_valid", S_VALID, 32'd3);
            if (i == 0) sb_push("seq_rptr", S_RPTR, 32'd0);
            step();
        end

        // redirect to an odd-word target, taken even while fetch stalls
        ready_i = 1'b0;
        jump(32'h1c00_0104);
        ready_i = 1'b1;
        sb_push("jmp_pc0", S_PC0, 32'h1c00_0104);
        sb_push("jmp_pc1", S_PC1, 32'h1c00_0108);
        sb_push("jmp_valid", S_VALID, 32'd1);
        step();
        sb_push("jmp_next_pc", S_PC0, 32'h1c00_0108);
        sb_push("jmp_next_valid", S_VALID, 32'd3);

        // direct branch learned from a correction
        correct(32'h1c00_0010, 32'h1c00_0200, 1'b1, 2'b01, 5'd0);
        jump(32'h1c00_0010);
        sb_push("dir_taken", S_TAKEN, 32'd1);
        sb_push("dir_lane", S_LANE, 32'd0);
        sb_push("dir_valid", S_VALID, 32'd1);
        sb_push("dir_tgt", S_TGT, 32'h1c00_0200);
        step();
        sb_push("dir_next_pc", S_PC0, 32'h1c00_0200);

        // call / return pair
        correct(32'h1c00_0020, 32'h1c00_0300, 1'b1, 2'b10, 5'd0);
        correct(32'h1c00_0300, 32'h0000_0000, 1'b1, 2'b11, 5'd0);
        jump(32'h1c00_0020);
        sb_push("call_taken", S_TAKEN, 32'd1);
        sb_push("call_tgt", S_TGT, 32'h1c00_0300);
        sb_push("call_rptr", S_RPTR, 32'd0);
        step();
        sb_push("ret_pc", S_PC0, 32'h1c00_0300);
        sb_push("ret_taken", S_TAKEN, 32'd1);
        sb_push("ret_tgt", S_TGT, 32'h1c00_0024);
        sb_push("ret_rptr", S_RPTR, 32'd1);
        step();
        sb_push("after_ret_pc", S_PC0, 32'h1c00_0024);
        sb_push("after_ret_rptr", S_RPTR, 32'd0);
        sb_push("lane0_behind_taken", S_TAKEN, 32'd0);
        sb_push("lane0_behind_valid", S_VALID, 32'd1);

        // nine unmatched calls wrap the 8-deep stack
        for (int i = 0; i < 9; i++) begin
            jump(32'h1c00_0020);
            sb_push("wrap_call_rptr", S_RPTR, 32'(i % 8));
            sb_push("wrap_call_taken", S_TAKEN, 32'd1);
            step();
        end
        sb_push("wrap_ret_pc", S_PC0, 32'h1c00_0300);
        sb_push("wrap_ret_rptr", S_RPTR, 32'd1);
        sb_push("wrap_ret_tgt", S_TGT, 32'h1c00_0024);
        step();
        sb_push("wrap_after_rptr", S_RPTR, 32'd0);

        // conditional branch trained taken three times with the history it will see
        correct(32'h1c00_0040, 32'h1c00_0080, 1'b1, 2'b00, 5'd7);
        correct(32'h1c00_0040, 32'h1c00_0080, 1'b1, 2'b00, 5'd7);
        correct(32'h1c00_0040, 32'h1c00_0080, 1'b1, 2'b00, 5'd7);
        jump(32'h1c00_0040);
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb_push("stall_pc", S_PC0, 32'h1c00_0040);
            sb_push("stall_valid", S_VALID, 32'd1);
            sb_push("cond_taken", S_TAKEN, 32'd1);
            sb_push("cond_hist", S_HIST, 32'd7);
            sb_push("stall_rptr", S_RPTR, 32'd0);
            step();
        end
        ready_i = 1'b1;
        sb_push("cond_tgt", S_TGT, 32'h1c00_0080);
        step();
        sb_push("cond_next_pc", S_PC0, 32'h1c00_0080);

        // stalled call block must not push
        jump(32'h1c00_0020);
        ready_i = 1'b0;
        sb_push("stall_call_rptr", S_RPTR, 32'd0);
        step();
        sb_push("stall_call_rptr2", S_RPTR, 32'd0);
        ready_i = 1'b1;
        step();
        sb_push("post_stall_call_rptr", S_RPTR, 32'd1);
        sb_push("post_stall_call_pc", S_PC0, 32'h1c00_0300);

        // mispredicted cond correction with echoed pointer 2
        ready_i = 1'b0;
        cor_valid_i = 1'b1; cor_pc_i = 32'h1c00_0600; cor_target_i = 32'h1c00_0700;
        cor_taken_i = 1'b0; cor_type_i = 2'b00; cor_hist_i = 5'd0;
        cor_miss_i = 1'b1; cor_ras_ptr_i = 3'd2;
        step();
        cor_valid_i = 1'b0; cor_miss_i = 1'b0;
`ifdef BPU_RAS_REPAIR_EN
        sb_push("repair_rptr", S_RPTR, 32'd2);
`else
        sb_push("norepair_rptr", S_RPTR, 32'd1);
`endif
        sb_push("repair_hold_pc", S_PC0, 32'h1c00_0300);
        step();

        @(negedge clk);
        #1;
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
